pipe_stage_skid: RTL and testbench

Parametrised successor to the fixed decode→execute pipeline register. One pipeline stage that carries an arbitrary-width control/data payload between pipe stages. It uses a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush that inserts an all-zero bubble. Instantiated between every pipe stage pair (F/D, D/E, E/M, M/W), with DATA_W sized per stage.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_skid.sv | 106 ++++++++++
 tb/tb_pipe_stage_skid.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int MAX_DATA_W    = 1024;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // All-zero payload; downstream control fields decode this as a NOP.
  function automatic logic [MAX_DATA_W-1:0] bubble(input int unsigned width);
    return {MAX_DATA_W{1'b0}} >> width;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush-to-bubble and
// saturating stall/flush statistics.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(bubble(DATA_W));

  // Handshake: a beat moves when valid && ready are both high at a rising
  // edge; in_ready comes straight from a flop, so it never depends on out_ready.
  occ_e              state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic issue;

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign issue     = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_data_d = in_data;
          state_d     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && issue) begin
          main_data_d = in_data;
        end else if (issue) begin
          state_d = OCC_EMPTY;
        end else if (accept) begin
          skid_data_d = in_data;
          state_d     = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (issue) begin
          main_data_d = skid_data_q;
          state_d     = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush drops everything held and anything offered; an issue this cycle
    // has already been taken by downstream.
    if (flush) state_d = OCC_EMPTY;
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_valid ? main_data_q : BUBBLE;
  assign occupancy = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush && (state_q != OCC_EMPTY)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, checked
// against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int stall_m = 0;
  int flush_m = 0;
  int total   = 0;
  int bad     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] id, input logic ordy);
    int sz;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    sz = exp_q.size();
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("out_data",  out_data, (sz > 0) ? exp_q[0] : 32'h0);
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("in_ready",  32'(in_ready), 32'(sz < 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    chk("flush_cnt", 32'(flush_cnt), 32'(flush_m));
    if (rst) begin
      exp_q.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (sz > 0 && !ordy && stall_m < CMAX) stall_m++;
      if (fl) begin
        if (sz > 0 && flush_m < CMAX) flush_m++;
        exp_q.delete();
      end else begin
        if (sz > 0 && ordy) void'(exp_q.pop_front());
        if (iv && sz < 2) exp_q.push_back(id);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, ordy);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then stream 1..8 at full rate
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
    idle(2, 1'b1);

    // backpressure: A, B fill the stage; a third offer is refused
    cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hD, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // flush while FULL with a payload offered
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
    #1 chk("flush_cnt_after_full_flush", 32'(flush_cnt), 32'd1);
    idle(2, 1'b1);

    // flush while EMPTY leaves flush_cnt alone
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1 chk("flush_cnt_empty_flush", 32'(flush_cnt), 32'd1);
    idle(1, 1'b1);

    // stall counter saturation
    cycle(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    idle(20, 1'b0);
    #1 chk("stall_cnt_saturated", 32'(stall_cnt), 32'(CMAX));

    // reset while FULL with counters nonzero, then a normal accept
    cycle(1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h88, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h99, 1'b0);
    #1 chk("stall_cnt_after_reset", 32'(stall_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1);
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0));
    end
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
